// File: rtl/ec_core_serial_harness.sv
// Serial test harness for a start/done EC core: shifts an operand frame in on one pin,
// launches the core, waits for done with a timeout and shifts a status-tagged result out.
module ec_core_serial_harness #(
    parameter int IN_WIDTH  = 283,
    parameter int OUT_WIDTH = 566,
    parameter int TIMEOUT   = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 si_bit,
    input  logic                 si_vld,
    output logic                 so_bit,
    output logic                 so_vld,
    output logic                 busy,
    output logic                 core_clr,
    output logic                 core_start,
    output logic [IN_WIDTH-1:0]  core_d,
    input  logic                 core_done,
    input  logic [OUT_WIDTH-1:0] core_res
);

    localparam int SRW  = OUT_WIDTH + 2;
    localparam int MAXW = (IN_WIDTH > SRW) ? IN_WIDTH : SRW;
    localparam int BW   = $clog2(MAXW + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, SHIFT_OUT} state_t;

    state_t              state_q, state_d;
    logic [IN_WIDTH-1:0] in_sr_q, in_sr_d;
    logic [SRW-1:0]      out_sr_q, out_sr_d;
    logic [BW-1:0]       bcnt_q, bcnt_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic                so_vld_q, so_vld_d;
    logic                timeout_hit;

    // Timeout fires in the WAIT cycle whose incremented count equals TIMEOUT.
    assign timeout_hit = (state_q == WAIT) && (tcnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        in_sr_d  = in_sr_q;
        out_sr_d = out_sr_q;
        bcnt_d   = bcnt_q;
        tcnt_d   = tcnt_q;
        so_vld_d = so_vld_q;
        if (clr) begin
            state_d  = IDLE;
            bcnt_d   = '0;
            tcnt_d   = '0;
            out_sr_d = '0;
            so_vld_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (si_vld) begin
                        in_sr_d = {in_sr_q[IN_WIDTH-2:0], si_bit};
                        if (bcnt_q == BW'(IN_WIDTH - 1)) begin
                            bcnt_d  = '0;
                            state_d = START;
                        end else begin
                            bcnt_d = bcnt_q + BW'(1);
                        end
                    end
                end
                START: begin
                    tcnt_d  = '0;
                    state_d = WAIT;
                end
                WAIT: begin
                    tcnt_d = tcnt_q + TW'(1);
                    if (core_done) begin
                        out_sr_d = {2'b01, core_res};
                        so_vld_d = 1'b1;
                        state_d  = SHIFT_OUT;
                    end else if (timeout_hit) begin
                        out_sr_d = {2'b10, {OUT_WIDTH{1'b0}}};
                        so_vld_d = 1'b1;
                        state_d  = SHIFT_OUT;
                    end
                end
                SHIFT_OUT: begin
                    // Zeros shift in, so out_sr is empty again once the frame ends.
                    out_sr_d = {out_sr_q[SRW-2:0], 1'b0};
                    if (bcnt_q == BW'(SRW - 1)) begin
                        bcnt_d   = '0;
                        so_vld_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            in_sr_q  <= '0;
            out_sr_q <= '0;
            bcnt_q   <= '0;
            tcnt_q   <= '0;
            so_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_sr_q  <= in_sr_d;
            out_sr_q <= out_sr_d;
            bcnt_q   <= bcnt_d;
            tcnt_q   <= tcnt_d;
            so_vld_q <= so_vld_d;
        end
    end

    // clr outranks a pending start, keeping core_start and core_clr exclusive.
    assign core_start = (state_q == START) && !clr;
    assign core_clr   = clr || (timeout_hit && !core_done);
    assign core_d     = in_sr_q;
    assign so_vld     = so_vld_q;
    assign so_bit     = out_sr_q[SRW-1];
    assign busy       = (state_q != IDLE);

endmodule
